mem_access_unit: RTL

Memory-stage load/store unit of the 5-stage RV64 pipeline. It consumes the EX/ME register contents, meaning the ALU-computed address and the forwarded store data selected in EX and latched into EX/ME. It issues one data-bus transaction per load or store and stalls the pipeline until the transaction completes. It returns aligned, sign- or zero-extended load data to WB.

---
 rtl/mem_access_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues one bus transaction per load/store,
// stalls ME until it completes, and returns lane-aligned, extended load data.
module mem_access_unit #(
    parameter int XLEN   = 64,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              me_valid,
    input  logic              me_mem_read,
    input  logic              me_mem_write,
    input  logic [2:0]        me_funct3,
    input  logic [XLEN-1:0]   me_addr,
    input  logic [XLEN-1:0]   me_store_data,
    output logic              me_stall,
    output logic [XLEN-1:0]   me_load_data,
    output logic              me_done,
    output logic              me_mem_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [STRB_W-1:0] mem_req_wstrb,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_rdata,
    output logic [1:0]        dbg_state
);

    // Bus handshake: a request transfers on a cycle where mem_req_valid and
    // mem_req_ready are both high; all mem_req_* fields are held stable from the
    // first valid cycle until that transfer. Exactly one mem_resp_valid pulse is
    // expected per transferred request, no earlier than the following cycle.
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_RESP = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [XLEN-1:0]     load_q, load_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                we_q, we_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [2:0]          off_q, off_d;

    logic [2:0]          off;
    logic                req_any, illegal, misalign, err_acc, legal_acc;
    logic [STRB_W-1:0]   strb_calc;
    logic [XLEN-1:0]     shifted, ext_data;

    assign off = me_addr[2:0];

    always_comb begin
        req_any   = me_valid & (me_mem_read | me_mem_write);
        illegal   = (me_mem_read & me_mem_write)
                  | (me_mem_write & me_funct3[2])
                  | (me_mem_read & (me_funct3 == 3'b111));
        misalign  = 1'b0;
        strb_calc = '0;
        case (me_funct3[1:0])
            2'b00: strb_calc = STRB_W'(8'h01) << off;
            2'b01: begin
                strb_calc = STRB_W'(8'h03) << off;
                misalign  = off[0];
            end
            2'b10: begin
                strb_calc = STRB_W'(8'h0F) << off;
                misalign  = (off[1:0] != 2'b00);
            end
            2'b11: begin
                strb_calc = STRB_W'(8'hFF);
                misalign  = (off != 3'b000);
            end
        endcase
        err_acc   = req_any & (illegal | misalign);
        legal_acc = req_any & ~(illegal | misalign);
    end

    // Loaded lane is brought down to bit 0 before truncation and extension.
    always_comb begin
        shifted = mem_resp_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ext_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  ext_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b010:  ext_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            3'b100:  ext_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  ext_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            3'b110:  ext_data = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: ext_data = shifted;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        load_d   = load_q;
        case (state_q)
            S_IDLE: begin
                if (legal_acc) begin
                    addr_d   = {me_addr[XLEN-1:3], 3'b000};
                    we_d     = me_mem_write;
                    wdata_d  = me_mem_write ? (me_store_data << {off, 3'b000}) : '0;
                    wstrb_d  = me_mem_write ? strb_calc : '0;
                    funct3_d = me_funct3;
                    off_d    = off;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready) state_d = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                if (mem_resp_valid) begin
                    if (!we_q) load_d = ext_data;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            off_q    <= 3'b000;
            load_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            load_q   <= load_d;
        end
    end

    // Combinational outputs are gated by rst_n so reset clears them immediately.
    assign mem_req_valid = (state_q == S_REQ);
    assign me_done       = (state_q == S_DONE);
    assign mem_req_we    = we_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wstrb = wstrb_q;
    assign me_load_data  = load_q;
    assign me_mem_err    = rst_n & (state_q == S_IDLE) & err_acc;
    assign me_stall      = rst_n & (((state_q == S_IDLE) & legal_acc)
                                   | (state_q == S_REQ)
                                   | (state_q == S_WAIT_RESP));
    assign dbg_state     = state_q;

endmodule
